// File: rtl/id_wb_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : id_wb_scheduler
// Brief    : Register-file write-port arbiter between W and the LL unit, with a
//            pending-write scoreboard and decode stall generation.
// Revision : 1.0 - initial release
// ============================================================================
module id_wb_scheduler #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int STARVE_LIMIT    = 8,
    parameter int CNT_W           = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             RegWriteW,
    input  logic [4:0]       RdW,
    input  logic [31:0]      ResultW,
    input  logic             ll_issue,
    input  logic [4:0]       ll_issue_rd,
    input  logic             ll_valid,
    input  logic [4:0]       ll_rd,
    input  logic [31:0]      ll_result,
    output logic             ll_ready,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       RdD,
    input  logic             RegWriteD,
    input  logic             ll_op_d,
    output logic             StallD,
    output logic             rf_we,
    output logic [4:0]       rf_a3,
    output logic [31:0]      rf_wd3,
    output logic [31:0]      pending,
    output logic [CNT_W-1:0] outstanding
);

    localparam int                    c_STARVE_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0]      c_MAX_OUT    = CNT_W'(MAX_OUTSTANDING);
    localparam logic [c_STARVE_W-1:0] c_STARVE_MAX = c_STARVE_W'(STARVE_LIMIT);

    logic [31:0]           r_pending;
    logic [31:0]           w_pending_nxt;
    logic [CNT_W-1:0]      r_outstanding;
    logic [CNT_W-1:0]      w_outstanding_nxt;
    logic [c_STARVE_W-1:0] r_starve_cnt;
    logic [c_STARVE_W-1:0] w_starve_nxt;
    logic                  w_accept;
    logic                  w_starve;
    logic                  w_hazard;

    // W owns the port whenever it writes, even to x0.
    always_comb begin
        ll_ready = reset && !RegWriteW;
        w_accept = ll_valid && ll_ready;
        rf_we    = 1'b0;
        rf_a3    = '0;
        rf_wd3   = '0;
        if (RegWriteW) begin
            rf_we  = reset && (RdW != 5'd0);
            rf_a3  = RdW;
            rf_wd3 = ResultW;
        end else if (ll_valid) begin
            rf_we  = reset && (ll_rd != 5'd0);
            rf_a3  = ll_rd;
            rf_wd3 = ll_result;
        end
    end

    always_comb begin
        w_pending_nxt = r_pending;
        if (w_accept) begin
            w_pending_nxt[ll_rd] = 1'b0;
        end
        if (ll_issue && (ll_issue_rd != 5'd0)) begin
            w_pending_nxt[ll_issue_rd] = 1'b1;
        end
        w_pending_nxt[0] = 1'b0;

        w_outstanding_nxt = r_outstanding;
        if (ll_issue && !w_accept && (r_outstanding != c_MAX_OUT)) begin
            w_outstanding_nxt = r_outstanding + CNT_W'(1);
        end else if (!ll_issue && w_accept && (r_outstanding != '0)) begin
            w_outstanding_nxt = r_outstanding - CNT_W'(1);
        end

        w_starve_nxt = '0;
        if (ll_valid && !ll_ready) begin
            w_starve_nxt = w_starve ? r_starve_cnt : r_starve_cnt + c_STARVE_W'(1);
        end
    end

    // A pending bit keeps stalling during its writeback cycle; no bypass path.
    always_comb begin
        w_starve = (r_starve_cnt == c_STARVE_MAX);
        w_hazard = ((Rs1D != 5'd0) && r_pending[Rs1D])
                || ((Rs2D != 5'd0) && r_pending[Rs2D])
                || (RegWriteD && (RdD != 5'd0) && r_pending[RdD])
                || (ll_op_d && (r_outstanding == c_MAX_OUT));
        StallD   = reset && (w_hazard || w_starve);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pending     <= '0;
            r_outstanding <= '0;
            r_starve_cnt  <= '0;
        end else begin
            r_pending     <= w_pending_nxt;
            r_outstanding <= w_outstanding_nxt;
            r_starve_cnt  <= w_starve_nxt;
        end
    end

    assign pending     = r_pending;
    assign outstanding = r_outstanding;

    a_issue_overflow: assert property (@(posedge clk) disable iff (!reset)
        !(ll_issue && (r_outstanding == c_MAX_OUT)));
    a_accept_underflow: assert property (@(posedge clk) disable iff (!reset)
        !(w_accept && (r_outstanding == '0)));

endmodule
`default_nettype wire

// File: doc/id_wb_scheduler.md
Name: id_wb_scheduler

Overview:
- Arbitrates the single register-file write port between the in-order writeback (W stage) and a long-latency unit (LL: multiply/divide) that completes out of order.
- Keeps a 32-entry pending-write scoreboard of destinations with outstanding LL results.
- Generates StallD for the decode stage on RAW/WAW hits against pending registers, when LL capacity is full, or when the LL result is being starved.
- Sits between the decode stage, the W stage and the LL unit, and drives the register file's we3/a3/wd3.

Parameters:
- MAX_OUTSTANDING, 4, maximum in-flight LL operations (1..7).
- STARVE_LIMIT, 8, consecutive refused LL-valid cycles before decode is stalled to drain W.
- CNT_W, 3, width of the outstanding counter; must hold MAX_OUTSTANDING.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous active-low reset.
- RegWriteW  in  1  W-stage write enable.
- RdW  in  5  W-stage destination.
- ResultW  in  32  W-stage write data.
- ll_issue  in  1  pulse: an LL op leaves EX this cycle.
- ll_issue_rd  in  5  destination of the issuing LL op.
- ll_valid  in  1  LL result available.
- ll_rd  in  5  LL result destination.
- ll_result  in  32  LL result data.
- ll_ready  out  1  LL result accepted this cycle (handshake = ll_valid && ll_ready).
- Rs1D  in  5  decode source 1.
- Rs2D  in  5  decode source 2.
- RdD  in  5  decode destination.
- RegWriteD  in  1  decode instruction writes Rd.
- ll_op_d  in  1  decode instruction is an LL op.
- StallD  out  1  hold the F/D registers and insert a bubble into EX.
- rf_we  out  1  register-file write enable.
- rf_a3  out  5  register-file write address.
- rf_wd3  out  32  register-file write data.
- pending  out  32  scoreboard bits (bit 0 always 0).
- outstanding  out  CNT_W  in-flight LL count.

Behaviour:
- **Reset (reset==0 at edge):** pending=0, outstanding=0, starve_cnt=0.
  - While reset is low, ll_ready, rf_we and StallD are forced to 0.
- **Write-port arbitration (combinational, 0 latency):**
  - W has absolute priority; the W stage is never stalled.
  - ll_ready = !RegWriteW. Writes with a3=0 still count as port use.
  - If RegWriteW=1: rf_we=(RdW!=0), rf_a3=RdW, rf_wd3=ResultW.
  - Else if ll_valid=1: rf_we=(ll_rd!=0), rf_a3=ll_rd, rf_wd3=ll_result.
  - Else rf_we=0 and rf_a3/rf_wd3 are don't-care (driven 0).
  - The LL unit holds ll_valid, ll_rd and ll_result stable until accepted.
- **Scoreboard (registered):**
  - On ll_issue with ll_issue_rd!=0, set pending[ll_issue_rd].
  - On LL accept, clear pending[ll_rd].
  - Same register set and cleared in one cycle: set wins.
  - pending[0] is never set.
- **Outstanding counter:**
  - +1 on ll_issue (including rd=x0); −1 on LL accept; both in one cycle → unchanged.
  - Issue while outstanding==MAX_OUTSTANDING, or accept while outstanding==0, is a protocol violation.
    - Flag with a simulation assertion; the counter saturates.
- **Starve counter:**
  - Increments (saturating at STARVE_LIMIT) each cycle ll_valid && !ll_ready.
  - Clears on accept or when ll_valid==0.
  - starve = (starve_cnt == STARVE_LIMIT).
- **StallD (combinational from registered state plus decode inputs), OR of:**
  - Rs1D!=0 && pending[Rs1D].
  - Rs2D!=0 && pending[Rs2D].
  - RegWriteD && RdD!=0 && pending[RdD] (WAW).
  - ll_op_d && outstanding==MAX_OUTSTANDING.
  - starve.
- **Pending-bit timing:**
  - A pending bit still stalls in the cycle its LL result is written; the bit clears at the next edge.
  - No same-cycle regfile bypass is required.
- **Starvation drain:**
  - StallD bubbles propagate to W within 3 cycles, so RegWriteW drops and the LL result is accepted.
  - starve_cnt then clears and StallD releases, unless another stall condition holds.
- **Mid-operation reset:** all scoreboard and counter state is discarded. The LL unit is reset by the same reset.

Test Plan:
1. Reset low 2 cycles with ll_valid=1 and RegWriteW=1 → rf_we=0, ll_ready=0, StallD=0; after release pending=0 and outstanding=0.
2. ll_issue rd=5; next cycle Rs1D=5 → StallD=1. ll_valid rd=5 result=0x1234 with RegWriteW=0 → ll_ready=1, rf_we=1, a3=5, wd3=0x1234; StallD=1 in that cycle, 0 the cycle after; pending[5]=0.
3. RegWriteW=1 RdW=3 and ll_valid=1 rd=7 in the same cycle → rf_a3=3, wd3=ResultW, ll_ready=0. Next cycle RegWriteW=0 → rd=7 written.
4. Four ll_issue to rd 1,2,3,4; decode ll_op_d=1 with unrelated regs → StallD=1 while outstanding==4. Accept one result → outstanding=3 and StallD drops the following cycle.
5. ll_valid held with RegWriteW=1 for 8 cycles → StallD asserts on cycle 9. Drop RegWriteW → accept, starve_cnt=0, StallD=0 next cycle.
6. ll_issue rd=9 and LL accept rd=9 in the same cycle → pending[9]=1, outstanding unchanged. Issue with rd=0 → pending unchanged, outstanding+1; its LL accept gives rf_we=0, ll_ready=1.
